// File: rtl/sram_pkg.sv
// sram_pkg: shared state type and helpers for the 1R1W masked SRAM.
package sram_pkg;
    typedef enum logic {ST_INIT, ST_READY} state_e;

    localparam int MAX_W  = 1024;
    localparam int MAX_AW = 10;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Spreads each mask bit over its granule; callers cast to and from MAX_W.
    function automatic logic [MAX_W-1:0] mask_expand(input logic [MAX_W-1:0] m, input int gran);
        logic [MAX_W-1:0] e;
        for (int i = 0; i < MAX_W; i++) e[MAX_AW'(i)] = m[MAX_AW'(i / gran)];
        return e;
    endfunction
endpackage

// File: rtl/sram_array_core.sv
// sram_array_core: raw storage with a bit-enabled write port and a registered read port, no reset.
module sram_array_core #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wbe_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we_i) mem_q[waddr_i] <= (mem_q[waddr_i] & ~wbe_i) | (wdata_i & wbe_i);
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/sram_1r1w_masked_init.sv
// sram_1r1w_masked_init: 1R1W masked SRAM with write-first bypass, optional output stage
// and post-reset zero-fill sequencer.
module sram_1r1w_masked_init import sram_pkg::*; #(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 512,
    parameter int ADDR_W    = clog2(DEPTH),
    parameter int MASK_GRAN = 8,
    parameter bit OUT_REG   = 1'b0,
    parameter bit INIT_ZERO = 1'b1,
    parameter int MASK_W    = DATA_W / MASK_GRAN
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              init_done,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_resp_valid,
    output logic [DATA_W-1:0] r_rdata,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [MASK_W-1:0] w_mask,
    input  logic [DATA_W-1:0] w_wdata
);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              rv1_q, rv2_q, byp_q, oor_q;
    logic [DATA_W-1:0] wd1_q, wbe1_q, hold_q;
    logic [DATA_W-1:0] wbe, core_rdata, merged;
    logic              init, rd_acc, wr_acc, rd_in, wr_in;

    assign init      = state_q == ST_INIT;
    assign init_done = !init;
    assign r_ready   = init_done;
    assign w_ready   = init_done;
    assign rd_acc    = r_valid && init_done;
    assign wr_acc    = w_valid && init_done;
    assign rd_in     = {1'b0, r_addr} < DEPTH_L;
    assign wr_in     = {1'b0, w_addr} < DEPTH_L;
    assign wbe       = DATA_W'(mask_expand(MAX_W'(w_mask), MASK_GRAN));

    sram_array_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_core (
        .clock   (clock),
        .we_i    (init || (wr_acc && wr_in)),
        .waddr_i (init ? cnt_q : w_addr),
        .wbe_i   (init ? '1 : wbe),
        .wdata_i (init ? '0 : w_wdata),
        .re_i    (rd_acc && rd_in),
        .raddr_i (r_addr),
        .rdata_o (core_rdata)
    );

    // The write that collided with a read is captured at acceptance, so later writes never leak in.
    assign merged = oor_q ? '0 : byp_q ? (core_rdata & ~wbe1_q) | (wd1_q & wbe1_q) : core_rdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT_ZERO ? ST_INIT : ST_READY;
            cnt_q   <= '0;
            rv1_q   <= 1'b0;
            rv2_q   <= 1'b0;
            byp_q   <= 1'b0;
            oor_q   <= 1'b0;
            wd1_q   <= '0;
            wbe1_q  <= '0;
            hold_q  <= '0;
        end else begin
            if (init) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == LAST) state_q <= ST_READY;
            end
            rv1_q <= rd_acc;
            rv2_q <= rv1_q;
            if (rd_acc) begin
                oor_q  <= !rd_in;
                byp_q  <= wr_acc && wr_in && (w_addr == r_addr);
                wd1_q  <= w_wdata;
                wbe1_q <= wbe;
            end
            if (rv1_q) hold_q <= merged;
        end
    end

    assign r_resp_valid = OUT_REG ? rv2_q : rv1_q;
    assign r_rdata      = (OUT_REG || !rv1_q) ? hold_q : merged;
endmodule

// File: tb/tb_sram_1r1w_masked_init.sv
// tb_sram_1r1w_masked_init: two SRAM configurations driven by vector tables, directed sequences
// and random traffic, checked against a behavioural array model.
module tb_sram_1r1w_masked_init;
    localparam int DA = 512;
    localparam int DB = 12;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    logic        a_init_done, a_r_valid, a_r_ready, a_r_resp_valid, a_w_valid, a_w_ready;
    logic [8:0]  a_r_addr, a_w_addr;
    logic [7:0]  a_w_mask;
    logic [63:0] a_r_rdata, a_w_wdata;
    logic        b_init_done, b_r_valid, b_r_ready, b_r_resp_valid, b_w_valid, b_w_ready;
    logic [3:0]  b_r_addr, b_w_addr, b_w_mask;
    logic [31:0] b_r_rdata, b_w_wdata;

    sram_1r1w_masked_init dut_a (
        .clock(clock), .reset_n(reset_n), .init_done(a_init_done),
        .r_valid(a_r_valid), .r_ready(a_r_ready), .r_addr(a_r_addr),
        .r_resp_valid(a_r_resp_valid), .r_rdata(a_r_rdata),
        .w_valid(a_w_valid), .w_ready(a_w_ready), .w_addr(a_w_addr),
        .w_mask(a_w_mask), .w_wdata(a_w_wdata)
    );

    sram_1r1w_masked_init #(.DATA_W(32), .DEPTH(DB), .MASK_GRAN(8), .OUT_REG(1'b1), .INIT_ZERO(1'b0)) dut_b (
        .clock(clock), .reset_n(reset_n), .init_done(b_init_done),
        .r_valid(b_r_valid), .r_ready(b_r_ready), .r_addr(b_r_addr),
        .r_resp_valid(b_r_resp_valid), .r_rdata(b_r_rdata),
        .w_valid(b_w_valid), .w_ready(b_w_ready), .w_addr(b_w_addr),
        .w_mask(b_w_mask), .w_wdata(b_w_wdata)
    );

    typedef struct {
        int          due;
        logic [63:0] d;
    } rsp_t;

    typedef struct {
        logic        rv;
        logic [8:0]  ra;
        logic        wv;
        logic [8:0]  wa;
        logic [7:0]  wm;
        logic [63:0] wd;
        logic        ev;
        logic [63:0] ed;
    } vec_t;

    logic [63:0] mem_a [DA];
    logic [31:0] mem_b [DB];
    rsp_t        qa[$], qb[$];
    logic [63:0] last_a, last_b;
    int          a_since, edge_n, n_chk, n_err;
    vec_t        tbl[10];

    function automatic logic [63:0] apply_mask(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int g = 0; g < 8; g++) if (m[g]) r[g*8 +: 8] = nw[g*8 +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    task automatic chk_b(input logic v, input logic [31:0] d);
        chk("b_seq", 64'({b_r_resp_valid, b_r_rdata}), 64'({v, d}));
    endtask

    task automatic idle();
        {a_r_valid, a_w_valid, b_r_valid, b_w_valid} = 4'b0;
    endtask

    task automatic tick();
        logic ar, aw, br, bw;
        rsp_t r;
        ar = a_r_valid && a_since >= DA;
        aw = a_w_valid && a_since >= DA;
        br = b_r_valid;
        bw = b_w_valid;
        @(posedge clock);
        edge_n++;
        if (aw) mem_a[a_w_addr] = apply_mask(mem_a[a_w_addr], a_w_wdata, a_w_mask);
        if (ar) qa.push_back('{edge_n, mem_a[a_r_addr]});
        if (bw && int'(b_w_addr) < DB)
            mem_b[b_w_addr] = 32'(apply_mask(64'(mem_b[b_w_addr]), 64'(b_w_wdata), 8'(b_w_mask)));
        if (br) qb.push_back('{edge_n + 1, int'(b_r_addr) < DB ? 64'(mem_b[b_r_addr]) : 64'h0});
        if (a_since < DA) begin
            a_since++;
            if (a_since == DA) foreach (mem_a[i]) mem_a[i] = '0;
        end
        #1;
        chk("a_ready", 64'({a_init_done, a_r_ready, a_w_ready}), a_since >= DA ? 64'd7 : 64'd0);
        chk("b_ready", 64'({b_init_done, b_r_ready, b_w_ready}), 64'd7);
        if (qa.size() > 0 && qa[0].due == edge_n) begin
            r = qa.pop_front();
            last_a = r.d;
            chk("a_resp_valid", 64'(a_r_resp_valid), 64'd1);
        end else chk("a_resp_valid", 64'(a_r_resp_valid), 64'd0);
        chk("a_rdata", a_r_rdata, last_a);
        if (qb.size() > 0 && qb[0].due == edge_n) begin
            r = qb.pop_front();
            last_b = r.d;
            chk("b_resp_valid", 64'(b_r_resp_valid), 64'd1);
        end else chk("b_resp_valid", 64'(b_r_resp_valid), 64'd0);
        chk("b_rdata", 64'(b_r_rdata), last_b);
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        #1;
        chk("rst_a_flags", 64'({a_init_done, a_r_ready, a_w_ready, a_r_resp_valid}), 64'd0);
        chk("rst_a_rdata", a_r_rdata, 64'd0);
        chk("rst_b_flags", 64'({b_init_done, b_r_ready, b_w_ready, b_r_resp_valid}), 64'b1110);
        chk("rst_b_rdata", 64'(b_r_rdata), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        qa.delete();
        qb.delete();
        last_a  = '0;
        last_b  = '0;
        a_since = 0;
        reset_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 9'd5, 1'b0, 9'd0, 8'h00, 64'h0, 1'b1, 64'h0};
        tbl[1] = '{1'b0, 9'd0, 1'b1, 9'd3, 8'hFF, 64'h1122334455667788, 1'b0, 64'h0};
        tbl[2] = '{1'b0, 9'd0, 1'b1, 9'd3, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0, 64'h0};
        tbl[3] = '{1'b1, 9'd3, 1'b0, 9'd0, 8'h00, 64'h0, 1'b1, 64'h11223344AAAAAAAA};
        tbl[4] = '{1'b0, 9'd0, 1'b1, 9'd8, 8'hFF, 64'h0123456789ABCDEF, 1'b0, 64'h11223344AAAAAAAA};
        tbl[5] = '{1'b1, 9'd7, 1'b1, 9'd7, 8'h01, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h00000000000000FF};
        tbl[6] = '{1'b1, 9'd8, 1'b1, 9'd7, 8'hF0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0123456789ABCDEF};
        tbl[7] = '{1'b1, 9'd7, 1'b0, 9'd0, 8'h00, 64'h0, 1'b1, 64'hFFFFFFFF000000FF};
        tbl[8] = '{1'b1, 9'd9, 1'b1, 9'd9, 8'h00, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0};
        tbl[9] = '{1'b0, 9'd0, 1'b0, 9'd0, 8'h00, 64'h0, 1'b0, 64'h0};
        n_chk = 0;
        n_err = 0;
        edge_n = 0;
        {a_r_addr, a_w_addr, a_w_mask, a_w_wdata} = '0;
        {b_r_addr, b_w_addr, b_w_mask, b_w_wdata} = '0;
        idle();
        #2;
        do_reset();

        // A zero-fills while a read of entry 5 is held; B runs directed traffic meanwhile.
        for (int i = 0; i < DA; i++) begin
            idle();
            a_r_valid = 1'b1;
            a_r_addr  = 9'd5;
            if (i < DB) begin
                b_w_valid = 1'b1; b_w_addr = 4'(i); b_w_mask = 4'hF; b_w_wdata = 32'hB000_0000 | 32'(i);
            end
            case (i)
                12: begin b_w_valid = 1'b1; b_w_addr = 4'd3; b_w_mask = 4'h0; b_w_wdata = 32'hFFFF_FFFF; end
                13: begin b_r_valid = 1'b1; b_r_addr = 4'd3; end
                20, 21, 22: begin b_r_valid = 1'b1; b_r_addr = 4'(i - 20); end
                30: begin
                    b_w_valid = 1'b1; b_w_addr = 4'd5; b_w_mask = 4'hF; b_w_wdata = 32'h1234_5678;
                    b_r_valid = 1'b1; b_r_addr = 4'd5;
                end
                31: begin b_w_valid = 1'b1; b_w_addr = 4'd5; b_w_mask = 4'hF; b_w_wdata = 32'hFFFF_FFFF; end
                32: begin b_r_valid = 1'b1; b_r_addr = 4'd5; end
                40: begin b_r_valid = 1'b1; b_r_addr = 4'd13; end
                default: ;
            endcase
            tick();
            case (i)
                14: chk_b(1'b1, 32'hB000_0003);
                15: chk_b(1'b0, 32'hB000_0003);
                21: chk_b(1'b1, 32'hB000_0000);
                22: chk_b(1'b1, 32'hB000_0001);
                23: chk_b(1'b1, 32'hB000_0002);
                24, 25: chk_b(1'b0, 32'hB000_0002);
                31: chk_b(1'b1, 32'h1234_5678);
                32: chk_b(1'b0, 32'h1234_5678);
                33: chk_b(1'b1, 32'hFFFF_FFFF);
                41: chk_b(1'b1, 32'h0);
                DA - 2: chk("a_ready_511", 64'(a_r_ready), 64'd0);
                DA - 1: chk("a_ready_512", 64'(a_init_done), 64'd1);
                default: ;
            endcase
        end

        foreach (tbl[k]) begin
            idle();
            a_r_valid = tbl[k].rv; a_r_addr = tbl[k].ra;
            a_w_valid = tbl[k].wv; a_w_addr = tbl[k].wa; a_w_mask = tbl[k].wm; a_w_wdata = tbl[k].wd;
            tick();
            chk("a_vec_valid", 64'(a_r_resp_valid), 64'(tbl[k].ev));
            chk("a_vec_data", a_r_rdata, tbl[k].ed);
        end

        for (int i = 0; i < 2000; i++) begin
            a_r_valid = 1'($urandom_range(0, 1));
            a_w_valid = 1'($urandom_range(0, 1));
            a_r_addr  = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, DA - 1)) : 9'($urandom_range(0, 15));
            a_w_addr  = 9'($urandom_range(0, 15));
            a_w_mask  = 8'($urandom);
            a_w_wdata = {$urandom, $urandom};
            b_r_valid = 1'($urandom_range(0, 1));
            b_w_valid = 1'($urandom_range(0, 1));
            b_r_addr  = 4'($urandom_range(0, 15));
            b_w_addr  = 4'($urandom_range(0, 15));
            b_w_mask  = 4'($urandom);
            b_w_wdata = $urandom;
            tick();
        end

        // Reset mid-fill after real data was written, then verify a complete fresh fill.
        do_reset();
        repeat (200) tick();
        do_reset();
        repeat (DA) tick();
        for (int i = 0; i < DA; i++) begin
            a_r_valid = 1'b1;
            a_r_addr  = 9'(i);
            tick();
        end
        idle();
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
